amp_meter: RTL
==============

# amp_meter

Windowed amplitude meter placed directly downstream of `FIR_HPF`. It consumes the filter's signed 12-bit output once per `f_s` sample period. Over each window of 2^LOG2_N samples it reports the peak absolute value and the mean absolute value, giving a per-window measure of residual amplitude after filtering. Everything runs in the system `clk` domain; `f_s` is treated as an asynchronous level and edge-detected internally.

## Interface
- LOG2_N, 8, log2 of window length in samples (legal range 1..12)
- CLIP_TH, 12'd2000, absolute-value threshold counted as a clip event (CLIP_EN builds only)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- f_s  in  1  sample-rate clock from the FIR stage; each rising edge is one sample
- din  in  12  signed FIR output, stable between `f_s` rising edges
- clr  in  1  synchronous window restart, active high
- peak  out  12  unsigned peak |din| of the last completed window
- mav  out  12  unsigned mean |din| of the last completed window
- valid  out  1  one-clk pulse when `peak`/`mav` update
- clip  out  1  1 if any sample in the last window had |din| >= CLIP_TH

## Operation
- `f_s` passes through a 2-flop synchronizer. A rising edge on the synchronized signal produces a 1-cycle `strobe`.
- Absolute value: abs = din<0 ? -din : din. din = -2048 saturates to 2047. Result is 11 bits, unsigned.
- Accumulator width is 11+LOG2_N bits and never overflows. Sample counter width is LOG2_N bits.
- FSM:
  - IDLE: after reset. Goes to ACC on the first `strobe`; that sample is accumulated.
  - ACC: on each `strobe`, acc += abs, pk = max(pk, abs), cnt++. When the strobe lands on cnt == 2^LOG2_N-1, go to LATCH.
  - LATCH: one cycle. peak <= pk, mav <= acc >> LOG2_N (truncation), clip <= clip_acc, valid = 1. acc, pk, cnt and clip_acc clear, then return to ACC.
- `clr` in any state clears acc, pk, cnt and clip_acc, and enters ACC. Output registers keep their values. `clr` and `strobe` in the same cycle: `clr` wins and the sample is dropped.
- A `strobe` arriving during LATCH cannot happen in practice (strobes are at least 2 clk apart). If one does arrive, it is accumulated as the first sample of the new window.

## Timing
- Reset values: peak = 0, mav = 0, valid = 0, clip = 0, state = IDLE, all accumulators 0.
- `f_s` rise sampled at clk edge k → `strobe` high in the cycle after edge k+2 → din captured at edge k+3.
- Last sample of a window captured at edge m → LATCH during cycle m..m+1 → outputs update and `valid` is high after edge m+1 for exactly one cycle.
- Outputs hold until the next LATCH, `rst` assertion, or forever.
- `rst` asserted mid-window aborts immediately with no `valid`. The first window after release starts at the first strobe.
- Minimum f_s period: 4 clk.

## Configuration
- AMP_METER_CLIP_EN defined: a clip_acc flag is set by any accumulated sample with abs >= CLIP_TH, and is latched into `clip` at LATCH.
- AMP_METER_CLIP_EN undefined: no clip logic is built, the `clip` port is tied to 0, and CLIP_TH is ignored.

## Structure
- Shared package `dsp_pkg`: DATA_W = 12, FSM state encodings (IDLE/ACC/LATCH), and the saturating-abs function for reuse by other meters.
- Sub-module `fs_edge_sync`: 2-flop synchronizer plus rising-edge detector producing `strobe`, with asynchronous active-low reset to 0. `FIR_HPF` may reuse it.

## Test plan
Benches use LOG2_N = 3, CLIP_TH = 2000, clk 2 MHz and f_s 20 kHz.
- Reset: hold rst low with f_s toggling → peak = 0, mav = 0, valid = 0, clip = 0 throughout, and no strobes accumulate.
- Constant: din = +100 for 8 strobes → one valid pulse 1 cycle after the 8th capture, with peak = 100, mav = 100, clip = 0.
- Alternating: din alternates +300/-500 for 8 strobes → peak = 500, mav = 400. Then an all-zero window → peak = 0, mav = 0.
- Saturation: din = -2048 for 8 strobes → peak = 2047, mav = 2047. clip = 1 with AMP_METER_CLIP_EN, 0 without.
- clr mid-window: 4 samples of +1000, then a clr pulse coincident with a strobe, then 8 samples of +10 → a single valid with peak = 10, mav = 10. Outputs are unchanged before that valid.
- Reset mid-window: 5 samples of +700, then a rst pulse → outputs go to 0 asynchronously. The next valid appears only after 8 post-reset strobes.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: data width, meter FSM states, result payload and saturating abs.
package dsp_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned ABS_W  = DATA_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_LATCH = 2'd2
    } meter_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] peak;
        logic [DATA_W-1:0] mav;
        logic              clip;
    } amp_result_t;

    // |x| as an unsigned ABS_W value; the most negative input saturates to full scale.
    function automatic logic [ABS_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] w_neg;
        w_neg = DATA_W'(-x);
        if (x == {1'b1, {ABS_W{1'b0}}}) begin
            return {ABS_W{1'b1}};
        end else if (x[DATA_W-1]) begin
            return w_neg[ABS_W-1:0];
        end else begin
            return x[ABS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fs_edge_sync.sv
// Two-flop synchronizer for an asynchronous sample clock plus a registered
// rising-edge detector that emits a one-cycle strobe.
module fs_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_strobe
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_strobe <= r_sync & ~r_sync_d;
        end
    end

    assign o_strobe = r_strobe;

endmodule

// File: rtl/amp_meter.sv
// Windowed peak / mean-absolute amplitude meter for the FIR_HPF output.
// Optional clip detection is built when AMP_METER_CLIP_EN is defined.
module amp_meter
    import dsp_pkg::*;
#(
    parameter int unsigned       LOG2_N  = 8,
    parameter logic [DATA_W-1:0] CLIP_TH = 12'd2000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_s,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     clr,
    output logic        [DATA_W-1:0] peak,
    output logic        [DATA_W-1:0] mav,
    output logic                     valid,
    output logic                     clip
);

    localparam int unsigned      ACC_W    = ABS_W + LOG2_N;
    localparam int unsigned      CNT_W    = LOG2_N;
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    logic              w_strobe;
    logic [ABS_W-1:0]  w_abs;
    meter_state_e      r_state;
    meter_state_e      w_state_nxt;
    logic              w_clear;
    logic              w_acc_en;
    logic              w_latch;
    logic              w_clip_win;
    logic [ACC_W-1:0]  r_acc;
    logic [ABS_W-1:0]  r_pk;
    logic [CNT_W-1:0]  r_cnt;
    amp_result_t       r_res;
    logic              r_valid;

    fs_edge_sync u_fs_sync (
        .clk      (clk),
        .rst_n    (rst),
        .i_async  (f_s),
        .o_strobe (w_strobe)
    );

    assign w_abs = sat_abs(din);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_ACC;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_strobe) w_state_nxt = ST_ACC;
                ST_ACC:   if (w_strobe && (r_cnt == CNT_LAST)) w_state_nxt = ST_LATCH;
                ST_LATCH: w_state_nxt = ST_ACC;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // clr takes priority over both accumulation and latching.
    always_comb begin
        w_clear  = 1'b0;
        w_acc_en = 1'b0;
        w_latch  = 1'b0;
        if (clr) begin
            w_clear = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:  w_acc_en = w_strobe;
                ST_ACC:   w_acc_en = w_strobe;
                ST_LATCH: begin
                    w_latch  = 1'b1;
                    w_acc_en = w_strobe;
                end
                default:  w_acc_en = 1'b0;
            endcase
        end
    end

    // A strobe during LATCH seeds the next window instead of being lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_pk  <= '0;
            r_cnt <= '0;
        end else if (w_clear) begin
            r_acc <= '0;
            r_pk  <= '0;
            r_cnt <= '0;
        end else if (w_latch) begin
            r_acc <= w_acc_en ? ACC_W'(w_abs) : '0;
            r_pk  <= w_acc_en ? w_abs : '0;
            r_cnt <= w_acc_en ? CNT_W'(1) : '0;
        end else if (w_acc_en) begin
            r_acc <= r_acc + ACC_W'(w_abs);
            r_pk  <= (w_abs > r_pk) ? w_abs : r_pk;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef AMP_METER_CLIP_EN
    logic r_clip_acc;
    logic w_over;

    assign w_over = (DATA_W'(w_abs) >= CLIP_TH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clip_acc <= 1'b0;
        end else if (w_clear) begin
            r_clip_acc <= 1'b0;
        end else if (w_latch) begin
            r_clip_acc <= w_acc_en & w_over;
        end else if (w_acc_en) begin
            r_clip_acc <= r_clip_acc | w_over;
        end
    end

    assign w_clip_win = r_clip_acc;
    assign clip       = r_res.clip;
`else
    logic w_unused_clip;

    assign w_clip_win    = 1'b0;
    assign clip          = 1'b0;
    assign w_unused_clip = ^{CLIP_TH, r_res.clip};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_latch;
            if (w_latch) begin
                r_res.peak <= DATA_W'(r_pk);
                r_res.mav  <= DATA_W'(r_acc >> LOG2_N);
                r_res.clip <= w_clip_win;
            end
        end
    end

    assign peak  = r_res.peak;
    assign mav   = r_res.mav;
    assign valid = r_valid;

endmodule
